instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  XLEN  byte address of the request.
REQ-007 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid, one per granted request, one or more cycles after the grant.
REQ-009 SHALL have port imem_rdata  input  XLEN  instruction word.
REQ-010 SHALL have port redirect_valid  input  1  redirect fetch to redirect_pc.
REQ-011 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-012 SHALL have port instr_valid  output  1  PC/Instr valid for the decode stage.
REQ-013 SHALL have port instr_ready  input  1  decode stage consumes the current PC/Instr.
REQ-014 SHALL have port PC  output  XLEN  address of the presented instruction.
REQ-015 SHALL have port Instr  output  XLEN  presented instruction.
REQ-016 SHALL have port fetch_err  output  1  misaligned redirect flag; present only with FETCH_ALIGN_CHECK_EN.

Function
REQ-017 SHALL hold a fetch_pc register, a 2-entry {PC, Instr} FIFO and an FSM with states IDLE, REQ, WAIT, DRAIN.
REQ-018 SHALL have at most one request outstanding: granted with rvalid not yet returned.
REQ-019 IDLE -> REQ when FIFO occupancy plus outstanding count < 2; drive imem_req=1 with imem_addr=fetch_pc.
REQ-020 In REQ, imem_req and imem_addr SHALL stay stable until imem_gnt; on gnt -> WAIT, fetch_pc += 4 modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
REQ-021 In WAIT, on imem_rvalid push {address, imem_rdata} into the FIFO; then -> REQ if space remains, else -> IDLE.
REQ-022 instr_valid SHALL equal FIFO non-empty; PC/Instr SHALL show the FIFO head; pop when instr_valid && instr_ready.
REQ-023 Push and pop in the same cycle SHALL be allowed at any occupancy, including full.
REQ-024 When empty: Instr = 32'h0000_0013 (NOP), PC = fetch_pc.
REQ-025 Redirect (any state): flush FIFO, set fetch_pc = redirect_pc, ignore instr_ready that cycle.
REQ-026 Redirect with no request outstanding SHALL -> REQ next cycle, imem_addr = redirect_pc.
REQ-027 Redirect while in WAIT, or in REQ with gnt the same cycle, SHALL -> DRAIN; the pending rvalid is discarded, then -> REQ.
REQ-028 Redirect in REQ without gnt SHALL change imem_addr to redirect_pc on the next cycle; this is the only permitted address change before gnt.
REQ-029 rvalid together with redirect in the same cycle SHALL be discarded.
REQ-030 Latency: gnt in cycle N, rvalid in N+1 -> instr_valid=1 in N+2.

Reset
REQ-031 On reset: FSM=IDLE, fetch_pc=RESET_PC, FIFO empty, outstanding count=0, imem_req=0, instr_valid=0, Instr=NOP, PC=RESET_PC, fetch_err=0.
REQ-032 Reset asserted during WAIT SHALL abandon the request; any imem_rvalid arriving while nothing is outstanding SHALL be ignored.
REQ-033 First imem_req SHALL assert in the first cycle after reset deasserts.

Configuration
REQ-034 Macro FETCH_ALIGN_CHECK_EN defined: a redirect_pc with [1:0] != 0 SHALL set sticky fetch_err, flush the FIFO and hold IDLE with no requests until reset.
REQ-035 Macro undefined: the fetch_err port SHALL be absent and redirect_pc[1:0] SHALL be forced to 0.

Verification
REQ-036 Reset, gnt always 1, rvalid 1 cycle later, ready=1 -> PCs 0,4,8,... with the matching rdata; first instr_valid 3 cycles after reset deasserts.
REQ-037 ready=0 for 10 cycles -> FIFO holds 2 entries, imem_req=0; ready=1 -> PCs 0,4 in order, then fetching resumes at 8.
REQ-038 Redirect to 0x100 while in WAIT for 0x8 -> rvalid for 0x8 dropped, next request 0x100, next valid PC=0x100.
REQ-039 Redirect to 0xFFFF_FFFC -> PCs 0xFFFF_FFFC then 0x0.
REQ-040 gnt held 0 for 5 cycles -> imem_addr stable at the same value; one request completes after gnt.
REQ-041 With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_err=1, instr_valid=0, imem_req=0 until reset.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: one-outstanding imem fetcher feeding a 2-entry {PC,Instr} queue; gnt N, rvalid N+1 -> instr_valid N+2.
// Requests stall while queue plus outstanding is full (instr_ready low); FETCH_ALIGN_CHECK_EN adds sticky fetch_err.
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] Instr
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic            fetch_err
`endif
);

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_fifo_pc  [2];
    logic [XLEN-1:0] r_fifo_ins [2];
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [1:0]      r_count;

    logic            w_halted;
    logic            w_redir;
    logic            w_in_flight;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_count_nxt;
    logic [XLEN-1:0] w_redir_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_err;
    assign w_halted   = r_err;
    assign w_redir_pc = redirect_pc;
    assign fetch_err  = r_err;
`else
    assign w_halted   = 1'b0;
    assign w_redir_pc = redirect_pc & ~XLEN'(3);
`endif

    assign w_redir     = redirect_valid && !w_halted;
    assign w_in_flight = (r_state == S_WAIT) || (r_state == S_DRAIN);
    // A response racing a redirect belongs to the abandoned stream.
    assign w_push      = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != 2'd0);
    assign PC          = instr_valid ? r_fifo_pc[r_rd_ptr]  : r_fetch_pc;
    assign Instr       = instr_valid ? r_fifo_ins[r_rd_ptr] : NOP;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else begin
            if (w_redir) begin
                r_count  <= 2'd0;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]  <= r_req_addr;
                    r_fifo_ins[r_wr_ptr] <= imem_rdata;
                    r_wr_ptr             <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= w_count_nxt;
            end

`ifdef FETCH_ALIGN_CHECK_EN
            if (w_redir && (redirect_pc[1:0] != 2'b00)) begin
                r_err      <= 1'b1;
                r_state    <= S_IDLE;
                r_fetch_pc <= w_redir_pc;
            end else
`endif
            if (w_redir) begin
                r_fetch_pc <= w_redir_pc;
                // Drain only if a response is still owed after this cycle.
                if ((w_in_flight && !imem_rvalid) || ((r_state == S_REQ) && imem_gnt)) begin
                    r_state <= S_DRAIN;
                end else begin
                    r_state <= S_REQ;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_halted && (r_count != 2'd2)) begin
                            r_state <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (imem_gnt) begin
                            r_req_addr <= r_fetch_pc;
                            r_fetch_pc <= r_fetch_pc + XLEN'(4);
                            r_state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            r_state <= (w_count_nxt == 2'd2) ? S_IDLE : S_REQ;
                        end
                    end
                    S_DRAIN: begin
                        if (imem_rvalid) begin
                            r_state <= S_REQ;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table-driven redirect vectors, directed corner sequences, randomized traffic vs a stream model.
module tb_instr_fetch;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] PC;
    logic [31:0] Instr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .PC             (PC),
        .Instr          (Instr)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_err      (fetch_err)
`endif
    );

    typedef struct {
        logic [31:0] target;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;

    int vectors    = 0;
    int miscompares = 0;
    int consumed   = 0;

    // memory responder state and traffic knobs
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    bit          stray_rv;
    int          gnt_mode;
    int          rdy_mode;
    int          rv_min;
    int          rv_max;

    // stream model: next PC the decoder must see, next address the fetcher must request
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    bit          req_hold;
    logic [31:0] hold_addr;
    bit          halted_exp;
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] target_of(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cycle(input bit rv, input logic [31:0] rpc);
        bit gnt;
        bit real_rv;
        if (halted_exp) begin
            check_bit("halt_no_valid", instr_valid, 1'b0);
            check_bit("halt_no_req", imem_req, 1'b0);
        end
        if (req_hold) begin
            check_bit("req_stable", imem_req, 1'b1);
            check("addr_stable", imem_addr, hold_addr);
        end else if (imem_req) begin
            check("req_addr", imem_addr, exp_req);
        end
        check_bit("one_outstanding", imem_req && pend, 1'b0);
        if (!instr_valid) begin
            check("empty_instr", Instr, NOP);
            check("empty_pc", PC, exp_req);
        end

        case (gnt_mode)
            0:       gnt = 1'b1;
            1:       gnt = ($urandom_range(0, 1) == 1);
            default: gnt = 1'b0;
        endcase
        imem_gnt = imem_req && gnt;
        real_rv  = 1'b0;
        if (stray_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stray_rv    = 1'b0;
        end else if (pend && pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            real_rv     = 1'b1;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        case (rdy_mode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = ($urandom_range(0, 1) == 1);
            default: instr_ready = 1'b0;
        endcase
        redirect_valid = rv;
        redirect_pc    = rv ? rpc : $urandom;

        if (rv) begin
            if (!halted_exp) begin
                exp_pc   = target_of(rpc);
                exp_req  = target_of(rpc);
                req_hold = 1'b0;
                got_pc.delete();
                got_ins.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                if (rpc[1:0] != 2'b00) halted_exp = 1'b1;
`endif
            end
        end else begin
            if (instr_valid && instr_ready) begin
                check("pc", PC, exp_pc);
                check("instr", Instr, mem_word(exp_pc));
                got_pc.push_back(PC);
                got_ins.push_back(Instr);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            req_hold  = imem_req && !imem_gnt;
            hold_addr = imem_addr;
            if (imem_req && imem_gnt) exp_req = imem_addr + 32'd4;
        end

        if (real_rv) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = int'($urandom_range(rv_min, rv_max));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        check_bit("rst_req", imem_req, 1'b0);
        check_bit("rst_valid", instr_valid, 1'b0);
        check("rst_instr", Instr, NOP);
        check("rst_pc", PC, RST_PC);
`ifdef FETCH_ALIGN_CHECK_EN
        check_bit("rst_err", fetch_err, 1'b0);
`endif
        pend       = 1'b0;
        stray_rv   = 1'b0;
        req_hold   = 1'b0;
        halted_exp = 1'b0;
        exp_pc     = RST_PC;
        exp_req    = RST_PC;
        got_pc.delete();
        got_ins.delete();
        reset      = 1'b0;
    endtask

    task automatic run_until_got(input string name, input int n, input int budget);
        int k = 0;
        while (got_pc.size() < n && k < budget) begin
            cycle(1'b0, '0);
            k++;
        end
        check_bit(name, got_pc.size() >= n, 1'b1);
    endtask

    initial begin
        vec_t        tbl[$];
        logic [31:0] r;
        int          k;

        tbl.push_back('{32'h0000_0100, 32'h0000_0100, 32'h0000_0104});
        tbl.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000});
        tbl.push_back('{32'h0000_0040, 32'h0000_0040, 32'h0000_0044});
        tbl.push_back('{32'h8000_0000, 32'h8000_0000, 32'h8000_0004});
`ifndef FETCH_ALIGN_CHECK_EN
        tbl.push_back('{32'h0000_0102, 32'h0000_0100, 32'h0000_0104});
        tbl.push_back('{32'h0000_0FFF, 32'h0000_0FFC, 32'h0000_1000});
`endif

        gnt_mode = 0;
        rdy_mode = 0;
        rv_min   = 0;
        rv_max   = 0;
        do_reset(3);

        // first request right after reset, valid two edges after the grant
        cycle(1'b0, '0);
        check_bit("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, RST_PC);
        cycle(1'b0, '0);
        check_bit("valid_not_yet", instr_valid, 1'b0);
        cycle(1'b0, '0);
        check_bit("first_valid", instr_valid, 1'b1);
        check("first_pc", PC, 32'h0);
        run_until_got("stream_timeout", 4, 40);
        check("stream_pc0", got_pc[0], 32'h0);
        check("stream_pc1", got_pc[1], 32'h4);
        check("stream_pc3", got_pc[3], 32'hC);
        check("stream_ins2", got_ins[2], mem_word(32'h8));

        // decoder stalled: queue fills to two and requests stop
        do_reset(2);
        rdy_mode = 2;
        repeat (10) cycle(1'b0, '0);
        check_bit("full_valid", instr_valid, 1'b1);
        check_bit("full_noreq", imem_req, 1'b0);
        check("full_head", PC, 32'h0);
        rdy_mode = 0;
        cycle(1'b0, '0);
        check_bit("second_valid", instr_valid, 1'b1);
        check("second_pc", PC, 32'h4);
        run_until_got("resume_timeout", 3, 30);
        check("resume_pc2", got_pc[2], 32'h8);

        // redirect while waiting on 0x8
        do_reset(2);
        rv_min = 3;
        rv_max = 3;
        k = 0;
        while (!(imem_req && imem_addr == 32'h8) && k < 40) begin
            cycle(1'b0, '0);
            k++;
        end
        check_bit("req8_timeout", imem_req && imem_addr == 32'h8, 1'b1);
        cycle(1'b0, '0);
        cycle(1'b1, 32'h0000_0100);
        run_until_got("redir_timeout", 2, 40);
        check("redir_pc0", got_pc[0], 32'h100);
        check("redir_ins0", got_ins[0], mem_word(32'h100));
        check("redir_pc1", got_pc[1], 32'h104);

        // grant withheld for five cycles
        do_reset(2);
        rv_min   = 0;
        rv_max   = 0;
        gnt_mode = 2;
        repeat (6) cycle(1'b0, '0);
        check_bit("nogrant_req", imem_req, 1'b1);
        check("nogrant_addr", imem_addr, 32'h0);
        gnt_mode = 0;
        run_until_got("grant_timeout", 1, 20);
        check("grant_pc0", got_pc[0], 32'h0);

        // reset during WAIT, stale response arrives after reset
        do_reset(2);
        rv_min = 2;
        rv_max = 2;
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        do_reset(1);
        stray_rv = 1'b1;
        rv_min   = 0;
        rv_max   = 0;
        run_until_got("stale_timeout", 2, 30);
        check("stale_pc0", got_pc[0], 32'h0);
        check("stale_ins0", got_ins[0], mem_word(32'h0));

        // redirect vectors
        do_reset(2);
        repeat (3) cycle(1'b0, '0);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(1'b1, tbl[i].target);
            run_until_got("tbl_timeout", 2, 40);
            check("tbl_pc0", got_pc[0], tbl[i].pc0);
            check("tbl_pc1", got_pc[1], tbl[i].pc1);
            check("tbl_ins1", got_ins[1], mem_word(tbl[i].pc1));
        end

`ifdef FETCH_ALIGN_CHECK_EN
        // misaligned redirect halts fetch until reset
        do_reset(2);
        repeat (5) cycle(1'b0, '0);
        cycle(1'b1, 32'h0000_0102);
        repeat (10) cycle(1'b0, '0);
        check_bit("err_flag", fetch_err, 1'b1);
        check_bit("err_valid", instr_valid, 1'b0);
        check_bit("err_req", imem_req, 1'b0);
        cycle(1'b1, 32'h0000_0200);
        repeat (5) cycle(1'b0, '0);
        check_bit("err_sticky", fetch_err, 1'b1);
`endif

        // randomized traffic against the stream model
        do_reset(2);
        gnt_mode = 1;
        rdy_mode = 1;
        rv_min   = 0;
        rv_max   = 3;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                r = $urandom;
                if ($urandom_range(0, 3) == 0) r = r | 32'hFFFF_FFF0;
`ifdef FETCH_ALIGN_CHECK_EN
                r[1:0] = 2'b00;
`endif
                cycle(1'b1, r);
            end else begin
                cycle(1'b0, '0);
            end
        end
        check_bit("random_progress", consumed >= 100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
